// File: rtl/code_word_pkg.sv
// Shared constants, state encodings and the nibble-to-code encoder
// used by the serial code word receiver.
package code_word_pkg;

   localparam int CODE_W = 5;
   localparam int NIB_W  = 4;

   typedef enum logic {
      IDLE,
      SHIFT
   } rx_state_e;

   typedef enum logic {
      LOW,
      HIGH
   } phase_e;

   // Same equations as the combinational nibble encoder; bit 0 is out1.
   function automatic logic [CODE_W-1:0] encode(input logic [NIB_W-1:0] nib);
      logic i1, i2, i3, i4;
      logic [CODE_W-1:0] code;
      i1 = nib[0];
      i2 = nib[1];
      i3 = nib[2];
      i4 = nib[3];
      code[0] = (i2 & i3) | i1;
      code[1] = (~i3 & ~i1) | (~i2 & ~i1) | (i1 & i2 & i3);
      code[2] = i2 ^ i3;
      code[3] = ~i3;
      code[4] = i4;
      return code;
   endfunction

endpackage

// File: rtl/code_word_decode.sv
// Combinational inverse of the nibble encoder; a word is valid only
// when re-encoding the decoded nibble reproduces it exactly.
module code_word_decode
   import code_word_pkg::*;
(
   input  logic [CODE_W-1:0] code,
   output logic [NIB_W-1:0]  nibble,
   output logic              valid
);

   logic in1, in2, in3, in4;

   // out1 only carries in1 when in2&in3 is false; otherwise out2 does.
   always_comb begin
      in3 = ~code[3];
      in4 = code[4];
      in2 = code[2] ^ in3;
      in1 = (in2 & in3) ? code[1] : code[0];
   end

   assign nibble = {in4, in3, in2, in1};
   assign valid  = (encode(nibble) == code);

endmodule

// File: rtl/code_word_rx.sv
// Serial code word receiver: shifts in 5-bit words, decodes them to
// nibbles, pairs nibbles into bytes and offers them on valid/ready.
module code_word_rx
   import code_word_pkg::*;
(
   input  logic       clk,
   input  logic       reset_n,
   input  logic       code_bit,
   input  logic       code_en,
   input  logic       code_start,
   output logic [7:0] byte_data,
   output logic       byte_valid,
   input  logic       byte_ready,
   output logic       code_err,
   output logic       overrun,
   input  logic       clear_flags
);

   rx_state_e         state;
   phase_e            phase;
   logic [CODE_W-2:0] sr;
   logic [2:0]        cnt;
   logic [NIB_W-1:0]  low_nib;

   logic [CODE_W-1:0] word;
   logic [NIB_W-1:0]  dec_nib;
   logic              dec_valid;

   logic word_done;
   logic byte_formed;
   logic handshake;
   logic load_byte;
   logic err_set;
   logic ovr_set;

   // The completing bit is decoded straight off the input pin.
   assign word = {code_bit, sr};

   code_word_decode u_decode (
      .code   (word),
      .nibble (dec_nib),
      .valid  (dec_valid)
   );

   always_comb begin
      word_done   = (state == SHIFT) && code_en && !code_start &&
                    (cnt == 3'(CODE_W - 1));
      byte_formed = word_done && dec_valid && (phase == HIGH);
      handshake   = byte_valid && byte_ready;
      load_byte   = byte_formed && (!byte_valid || byte_ready);
      err_set     = word_done && !dec_valid;
      ovr_set     = byte_formed && byte_valid && !byte_ready;
   end

   // Bit collection: a start bit always begins a fresh word, even mid-word.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         sr    <= '0;
         cnt   <= '0;
      end else if (code_en) begin
         if (code_start) begin
            state <= SHIFT;
            sr    <= {code_bit, sr[CODE_W-2:1]};
            cnt   <= 3'd1;
         end else if (state == SHIFT) begin
            if (word_done) begin
               state <= IDLE;
               cnt   <= '0;
            end else begin
               sr  <= {code_bit, sr[CODE_W-2:1]};
               cnt <= cnt + 3'd1;
            end
         end
      end
   end

   // Nibble pairing, output register and sticky flags.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         phase      <= LOW;
         low_nib    <= '0;
         byte_data  <= 8'h00;
         byte_valid <= 1'b0;
         code_err   <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         if (word_done) begin
            if (!dec_valid) begin
               phase <= LOW;
            end else if (phase == LOW) begin
               low_nib <= dec_nib;
               phase   <= HIGH;
            end else begin
               phase <= LOW;
            end
         end

         if (load_byte) begin
            byte_data  <= {dec_nib, low_nib};
            byte_valid <= 1'b1;
         end else if (handshake) begin
            byte_valid <= 1'b0;
         end

         if (clear_flags) begin
            code_err <= 1'b0;
            overrun  <= 1'b0;
         end else begin
            if (err_set) code_err <= 1'b1;
            if (ovr_set) overrun <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_code_word_rx.sv
// Randomized self-checking bench for code_word_rx against a word-level
// reference model built from the encoding equations and pairing rules.
module tb_code_word_rx;

   logic       clk;
   logic       reset_n;
   logic       code_bit;
   logic       code_en;
   logic       code_start;
   logic [7:0] byte_data;
   logic       byte_valid;
   logic       byte_ready;
   logic       code_err;
   logic       overrun;
   logic       clear_flags;

   int checks;
   int errors;

   logic [7:0] exp_data;
   logic       exp_valid;
   logic       exp_err;
   logic       exp_ovr;
   logic       exp_high;
   logic [3:0] exp_low;

   code_word_rx dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .code_bit    (code_bit),
      .code_en     (code_en),
      .code_start  (code_start),
      .byte_data   (byte_data),
      .byte_valid  (byte_valid),
      .byte_ready  (byte_ready),
      .code_err    (code_err),
      .overrun     (overrun),
      .clear_flags (clear_flags)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [4:0] ref_encode(input logic [3:0] n);
      logic [4:0] c;
      c[0] = (n[1] & n[2]) | n[0];
      c[1] = (~n[2] & ~n[0]) | (~n[1] & ~n[0]) | (n[0] & n[1] & n[2]);
      c[2] = n[1] ^ n[2];
      c[3] = ~n[2];
      c[4] = n[3];
      return c;
   endfunction

   // Decode by searching the 16 legal code words.
   function automatic logic ref_lookup(input logic [4:0] c, output logic [3:0] n);
      n = 4'h0;
      for (int k = 0; k < 16; k++) begin
         if (ref_encode(4'(k)) == c) begin
            n = 4'(k);
            return 1'b1;
         end
      end
      return 1'b0;
   endfunction

   task automatic model_edge(input logic done, input logic [4:0] c);
      logic [3:0] n;
      logic hs, loaded, eset, oset;
      hs = exp_valid && byte_ready;
      loaded = 1'b0;
      eset = 1'b0;
      oset = 1'b0;
      if (done) begin
         if (ref_lookup(c, n)) begin
            if (!exp_high) begin
               exp_low  = n;
               exp_high = 1'b1;
            end else begin
               exp_high = 1'b0;
               if (!exp_valid || byte_ready) begin
                  exp_data = {n, exp_low};
                  loaded = 1'b1;
               end else begin
                  oset = 1'b1;
               end
            end
         end else begin
            eset = 1'b1;
            exp_high = 1'b0;
         end
      end
      if (loaded) exp_valid = 1'b1;
      else if (hs) exp_valid = 1'b0;
      if (clear_flags) begin
         exp_err = 1'b0;
         exp_ovr = 1'b0;
      end else begin
         exp_err = exp_err | eset;
         exp_ovr = exp_ovr | oset;
      end
   endtask

   task automatic tick(input logic done, input logic [4:0] c);
      @(posedge clk);
      #1;
      model_edge(done, c);
   endtask

   task automatic idle(input int n);
      code_en = 1'b0;
      code_start = 1'b0;
      repeat (n) tick(1'b0, 5'd0);
   endtask

   task automatic send_word(input logic [4:0] c, input int max_gap, input logic clr_last);
      for (int i = 0; i < 5; i++) begin
         if (max_gap > 0 && i > 0) idle($urandom_range(0, max_gap));
         code_bit   = c[i];
         code_en    = 1'b1;
         code_start = (i == 0);
         if (i == 4) clear_flags = clr_last;
         tick(i == 4, c);
      end
      code_en     = 1'b0;
      code_start  = 1'b0;
      clear_flags = 1'b0;
   endtask

   task automatic clear_all();
      clear_flags = 1'b1;
      byte_ready  = 1'b1;
      idle(1);
      clear_flags = 1'b0;
      byte_ready  = 1'b0;
   endtask

   task automatic test_reset();
      checks++; if (byte_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_data got %h want 00", byte_data); end
      checks++; if (byte_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b want 0", byte_valid); end
      checks++; if (code_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err got %b want 0", code_err); end
      checks++; if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL reset_ovr got %b want 0", overrun); end
   endtask

   task automatic test_exhaustive_decode();
      logic [3:0] perm [16];
      logic [3:0] tmp, n;
      int j;
      clear_all();
      send_word(ref_encode(4'h5), 0, 1'b0);
      checks++; if (byte_valid !== 1'b0) begin errors++; $display("[TB] FAIL a5_early_valid got %b want 0", byte_valid); end
      send_word(ref_encode(4'hA), 0, 1'b0);
      checks++; if (byte_valid !== 1'b1 || byte_data !== 8'hA5) begin errors++; $display("[TB] FAIL a5_byte got %b/%h want 1/a5", byte_valid, byte_data); end
      for (int k = 0; k < 16; k++) perm[k] = 4'(k);
      for (int k = 15; k > 0; k--) begin
         j = $urandom_range(0, k);
         tmp = perm[k]; perm[k] = perm[j]; perm[j] = tmp;
      end
      for (int k = 0; k < 16; k += 2) begin
         clear_all();
         send_word(ref_encode(perm[k]), 0, 1'b0);
         send_word(ref_encode(perm[k+1]), 0, 1'b0);
         checks++; if (byte_valid !== 1'b1 || byte_data !== {perm[k+1], perm[k]}) begin errors++; $display("[TB] FAIL decode_pair got %b/%h want 1/%h", byte_valid, byte_data, {perm[k+1], perm[k]}); end
         checks++; if (byte_data !== exp_data || code_err !== exp_err) begin errors++; $display("[TB] FAIL decode_model got %h/%b want %h/%b", byte_data, code_err, exp_data, exp_err); end
      end
      for (int c = 0; c < 32; c++) begin
         if (!ref_lookup(5'(c), n)) begin
            clear_all();
            send_word(5'(c), 0, 1'b0);
            checks++; if (code_err !== 1'b1 || exp_err !== 1'b1) begin errors++; $display("[TB] FAIL invalid_code %h got %b want 1", c, code_err); end
         end
      end
      clear_all();
      checks++; if (code_err !== 1'b0) begin errors++; $display("[TB] FAIL err_clear got %b want 0", code_err); end
   endtask

   task automatic test_hold();
      clear_all();
      send_word(ref_encode(4'h0), 0, 1'b0);
      send_word(ref_encode(4'hF), 0, 1'b0);
      for (int k = 0; k < 10; k++) begin
         checks++; if (byte_valid !== 1'b1 || byte_data !== 8'hF0) begin errors++; $display("[TB] FAIL hold_cycle%0d got %b/%h want 1/f0", k, byte_valid, byte_data); end
         idle(1);
      end
      byte_ready = 1'b1;
      idle(1);
      byte_ready = 1'b0;
      checks++; if (byte_valid !== 1'b0 || exp_valid !== 1'b0) begin errors++; $display("[TB] FAIL hold_release got %b want 0", byte_valid); end
   endtask

   task automatic test_invalid_drop();
      logic [3:0] a, b, c;
      clear_all();
      a = 4'($urandom); b = 4'($urandom); c = 4'($urandom);
      send_word(ref_encode(a), 0, 1'b0);
      send_word(5'b01000, 0, 1'b0);
      checks++; if (code_err !== 1'b1) begin errors++; $display("[TB] FAIL invalid_err got %b want 1", code_err); end
      send_word(ref_encode(b), 0, 1'b0);
      checks++; if (byte_valid !== 1'b0) begin errors++; $display("[TB] FAIL invalid_dropped got %b want 0", byte_valid); end
      send_word(ref_encode(c), 0, 1'b0);
      checks++; if (byte_valid !== 1'b1 || byte_data !== {c, b}) begin errors++; $display("[TB] FAIL invalid_clean got %b/%h want 1/%h", byte_valid, byte_data, {c, b}); end
   endtask

   task automatic test_overrun();
      logic [3:0] n [6];
      clear_all();
      for (int k = 0; k < 6; k++) n[k] = 4'($urandom);
      for (int k = 0; k < 4; k++) send_word(ref_encode(n[k]), 0, 1'b0);
      checks++; if (overrun !== 1'b1) begin errors++; $display("[TB] FAIL ovr_set got %b want 1", overrun); end
      checks++; if (byte_data !== {n[1], n[0]}) begin errors++; $display("[TB] FAIL ovr_keep got %h want %h", byte_data, {n[1], n[0]}); end
      send_word(ref_encode(n[4]), 0, 1'b0);
      send_word(ref_encode(n[5]), 0, 1'b1);
      checks++; if (overrun !== 1'b0 || exp_ovr !== 1'b0) begin errors++; $display("[TB] FAIL ovr_clear_prio got %b want 0", overrun); end
      checks++; if (byte_data !== {n[1], n[0]} || byte_valid !== 1'b1) begin errors++; $display("[TB] FAIL ovr_keep2 got %b/%h want 1/%h", byte_valid, byte_data, {n[1], n[0]}); end
   endtask

   task automatic test_restart_and_gaps();
      logic [3:0] a, b;
      logic [4:0] junk;
      for (int r = 0; r < 4; r++) begin
         clear_all();
         a = 4'($urandom); b = 4'($urandom); junk = 5'($urandom);
         for (int i = 0; i < 2; i++) begin
            code_bit = junk[i]; code_en = 1'b1; code_start = (i == 0);
            tick(1'b0, 5'd0);
         end
         send_word(ref_encode(a), 0, 1'b0);
         send_word(ref_encode(b), (r == 0) ? 0 : 3, 1'b0);
         checks++; if (byte_valid !== 1'b1 || byte_data !== {b, a} || code_err !== 1'b0) begin errors++; $display("[TB] FAIL restart_gap%0d got %b/%h/%b want 1/%h/0", r, byte_valid, byte_data, code_err, {b, a}); end
      end
   endtask

   task automatic test_back_to_back();
      logic [4:0] c;
      clear_all();
      for (int k = 0; k < 24; k++) begin
         byte_ready = 1'($urandom);
         if ($urandom_range(0, 3) != 0) c = ref_encode(4'($urandom));
         else c = 5'($urandom);
         send_word(c, 0, 1'b0);
         checks++; if (byte_valid !== exp_valid || byte_data !== exp_data || code_err !== exp_err || overrun !== exp_ovr) begin errors++; $display("[TB] FAIL b2b_word%0d got %b/%h/%b/%b want %b/%h/%b/%b", k, byte_valid, byte_data, code_err, overrun, exp_valid, exp_data, exp_err, exp_ovr); end
      end
      byte_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic [3:0] a, b;
      clear_all();
      send_word(ref_encode(4'($urandom)), 0, 1'b0);
      send_word(ref_encode(4'($urandom)), 0, 1'b0);
      send_word(5'b01000, 0, 1'b0);
      send_word(ref_encode(4'($urandom)), 0, 1'b0);
      code_bit = 1'b1; code_en = 1'b1; code_start = 1'b1;
      tick(1'b0, 5'd0);
      code_start = 1'b0;
      tick(1'b0, 5'd0);
      #2 reset_n = 1'b0;
      #1;
      checks++; if (byte_valid !== 1'b0 || byte_data !== 8'h00 || code_err !== 1'b0 || overrun !== 1'b0) begin errors++; $display("[TB] FAIL reset_mid got %b/%h/%b/%b want 0/00/0/0", byte_valid, byte_data, code_err, overrun); end
      code_en = 1'b0;
      #1 reset_n = 1'b1;
      exp_valid = 1'b0; exp_data = 8'h00; exp_err = 1'b0; exp_ovr = 1'b0; exp_high = 1'b0;
      idle(1);
      a = 4'($urandom); b = 4'($urandom);
      send_word(ref_encode(a), 0, 1'b0);
      checks++; if (byte_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_low_phase got %b want 0", byte_valid); end
      send_word(ref_encode(b), 0, 1'b0);
      checks++; if (byte_valid !== 1'b1 || byte_data !== {b, a}) begin errors++; $display("[TB] FAIL reset_next_byte got %b/%h want 1/%h", byte_valid, byte_data, {b, a}); end
   endtask

   initial begin
      checks = 0; errors = 0;
      exp_data = 8'h00; exp_valid = 1'b0; exp_err = 1'b0; exp_ovr = 1'b0;
      exp_high = 1'b0; exp_low = 4'h0;
      reset_n = 1'b0; code_bit = 1'b0; code_en = 1'b0; code_start = 1'b0;
      byte_ready = 1'b0; clear_flags = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk) reset_n = 1'b1;
      @(posedge clk);
      #1;
      test_reset();
      test_exhaustive_decode();
      test_hold();
      test_invalid_drop();
      test_overrun();
      test_restart_and_gaps();
      test_back_to_back();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
